julia_sched: RTL and testbench

- Frame-level scheduler for the Julia-set datapath.
- Walks the pixel grid and dispatches one pixel coordinate per cycle to NUM_ENG parallel iteration engines.
- Collects finished iteration counts in round-robin order and writes each one to the frame-buffer write port at its pixel address.
- Sits between the top-level frame control (driven from VS) and the engine array and frame buffer read by the VGA scan-out.

---
 rtl/julia_sched.sv | 165 ++++++++++++++++
 tb/tb_julia_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/julia_sched.sv
// rtl/julia_sched.sv - Julia-set frame scheduler: raster pixel dispatch and round-robin result write-back
module julia_sched #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int NUM_ENG = 4,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int ITW     = 8,
  parameter int AW      = 19
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   FRAME_REQ,
  output logic                   BUSY,
  output logic                   FRAME_DONE,
  input  logic [NUM_ENG-1:0]     ENG_READY,
  output logic [NUM_ENG-1:0]     ENG_START,
  output logic [XW-1:0]          ENG_X,
  output logic [YW-1:0]          ENG_Y,
  input  logic [NUM_ENG-1:0]     ENG_DONE,
  input  logic [NUM_ENG*ITW-1:0] ENG_ITER,
  output logic [NUM_ENG-1:0]     ENG_ACK,
  output logic                   FB_WE,
  output logic [AW-1:0]          FB_ADDR,
  output logic [ITW-1:0]         FB_DATA
);
  localparam int OW = $clog2(NUM_ENG + 1);
  localparam int RW = $clog2(NUM_ENG);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]         state;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [AW-1:0]      addr;
  logic [OW-1:0]      outstanding;
  logic [RW-1:0]      dispatch_rr;
  logic [RW-1:0]      collect_rr;
  logic [AW-1:0]      tag [NUM_ENG];

  logic [NUM_ENG-1:0] disp_elig;
  logic [NUM_ENG-1:0] coll_elig;
  logic               disp_go;
  logic               coll_go;
  logic [RW-1:0]      disp_k;
  logic [RW-1:0]      coll_k;
  logic               last_pix;
  logic               x_wrap;

  // First set bit at or after ptr; scanned backwards so the nearest candidate is the last one written.
  function automatic logic [RW:0] rr_pick(input logic [NUM_ENG-1:0] elig, input logic [RW-1:0] ptr);
    logic [RW:0]   r;
    logic [RW-1:0] jj;
    int            j;
    r = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_ENG) j = j - NUM_ENG;
      jj = RW'(j);
      if (elig[jj]) r = {1'b1, jj};
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] rr_next(input logic [RW-1:0] k);
    return (int'(k) == NUM_ENG - 1) ? '0 : k + 1'b1;
  endfunction

  always_comb begin
    disp_elig = (state == RUN) ? (ENG_READY & ~ENG_START) : '0;
    coll_elig = (state == RUN || state == DRAIN) ? (ENG_DONE & ~ENG_ACK) : '0;
    {disp_go, disp_k} = rr_pick(disp_elig, dispatch_rr);
    {coll_go, coll_k} = rr_pick(coll_elig, collect_rr);
    x_wrap   = (x == XW'(H_RES - 1));
    last_pix = x_wrap && (y == YW'(V_RES - 1));
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      outstanding <= '0;
      dispatch_rr <= '0;
      collect_rr  <= '0;
      for (int k = 0; k < NUM_ENG; k++) tag[k] <= '0;
      BUSY        <= 1'b0;
      FRAME_DONE  <= 1'b0;
      ENG_START   <= '0;
      ENG_X       <= '0;
      ENG_Y       <= '0;
      ENG_ACK     <= '0;
      FB_WE       <= 1'b0;
      FB_ADDR     <= '0;
      FB_DATA     <= '0;
    end else begin
      ENG_START  <= '0;
      ENG_ACK    <= '0;
      FB_WE      <= 1'b0;
      FRAME_DONE <= 1'b0;

      case (state)
        IDLE: begin
          if (FRAME_REQ) begin
            x           <= '0;
            y           <= '0;
            addr        <= '0;
            outstanding <= '0;
            dispatch_rr <= '0;
            collect_rr  <= '0;
            BUSY        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (disp_go && last_pix) state <= DRAIN;
        end
        DRAIN: begin
          if (outstanding == '0 && ENG_ACK == '0 && !coll_go) begin
            FRAME_DONE <= 1'b1;
            BUSY       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase

      if (disp_go) begin
        ENG_START     <= NUM_ENG'(1) << disp_k;
        ENG_X         <= x;
        ENG_Y         <= y;
        tag[disp_k]   <= addr;
        dispatch_rr   <= rr_next(disp_k);
        addr          <= addr + 1'b1;
        if (x_wrap) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end

      // Non-blocking read of tag[] returns the old value even if the same engine is re-dispatched now.
      if (coll_go) begin
        ENG_ACK    <= NUM_ENG'(1) << coll_k;
        FB_WE      <= 1'b1;
        FB_ADDR    <= tag[coll_k];
        FB_DATA    <= ENG_ITER[int'(coll_k)*ITW +: ITW];
        collect_rr <= rr_next(coll_k);
      end

      if (disp_go && !coll_go) outstanding <= outstanding + 1'b1;
      else if (!disp_go && coll_go) outstanding <= outstanding - 1'b1;
    end
  end

  a_outstanding_bound: assert property (@(posedge CLK) disable iff (!RST) outstanding <= OW'(NUM_ENG));

endmodule

// File: tb/tb_julia_sched.sv
// tb/tb_julia_sched.sv - directed vector table plus engine-model frame sequences for julia_sched
module tb_julia_sched;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int NE = 4;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        frame_req;
  logic        busy;
  logic        frame_done;
  logic [3:0]  eng_ready;
  logic [3:0]  eng_start;
  logic [9:0]  eng_x;
  logic [8:0]  eng_y;
  logic [3:0]  eng_done;
  logic [31:0] eng_iter;
  logic [3:0]  eng_ack;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;

  logic [3:0]  t_ready;
  logic [3:0]  t_done;
  logic [31:0] t_iter;
  logic        model_on;
  logic        stall;
  logic        clr;
  logic [3:0]  en_mask;
  logic [3:0]  free;
  logic [3:0]  m_done;
  logic [31:0] m_iter;
  logic [3:0]  pend;
  int          cnt [NE];
  int          lat [NE];
  logic [9:0]  px [NE];
  logic [8:0]  py [NE];

  int          n_vec = 0;
  int          n_bad = 0;

  int          wr_cnt, fdone_cnt, data_bad, busy_bad, start_cnt;
  int          hits [NPIX];
  logic [18:0] wlog [$];
  logic [18:0] dlog [$];

  assign eng_ready = model_on ? (free & en_mask & ~{4{stall}}) : t_ready;
  assign eng_done  = model_on ? m_done : t_done;
  assign eng_iter  = model_on ? m_iter : t_iter;

  julia_sched #(
    .H_RES(H), .V_RES(V), .NUM_ENG(NE), .XW(10), .YW(9), .ITW(8), .AW(19)
  ) dut (
    .CLK(clk), .RST(rst_n), .FRAME_REQ(frame_req), .BUSY(busy), .FRAME_DONE(frame_done),
    .ENG_READY(eng_ready), .ENG_START(eng_start), .ENG_X(eng_x), .ENG_Y(eng_y),
    .ENG_DONE(eng_done), .ENG_ITER(eng_iter), .ENG_ACK(eng_ack),
    .FB_WE(fb_we), .FB_ADDR(fb_addr), .FB_DATA(fb_data)
  );

  // Engine model: fixed per-engine latency, result = x + y, drops DONE the cycle after ACK.
  always @(negedge clk) begin
    for (int k = 0; k < NE; k++) begin
      if (!rst_n) begin
        free[k]   = 1'b1;
        pend[k]   = 1'b0;
        cnt[k]    = 0;
        m_done[k] = 1'b0;
        m_iter[k*8 +: 8] = 8'h00;
      end else begin
        if (eng_ack[k]) begin
          m_done[k] = 1'b0;
          free[k]   = 1'b1;
        end
        if (eng_start[k]) begin
          free[k] = 1'b0;
          pend[k] = 1'b1;
          cnt[k]  = lat[k];
          px[k]   = eng_x;
          py[k]   = eng_y;
        end else if (pend[k]) begin
          if (cnt[k] > 1) cnt[k] = cnt[k] - 1;
          else begin
            pend[k]   = 1'b0;
            m_done[k] = 1'b1;
            m_iter[k*8 +: 8] = 8'(int'(px[k]) + int'(py[k]));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      wr_cnt = 0; fdone_cnt = 0; data_bad = 0; busy_bad = 0; start_cnt = 0;
      for (int a = 0; a < NPIX; a++) hits[a] = 0;
      wlog.delete();
      dlog.delete();
    end else begin
      if (fb_we) begin
        wr_cnt++;
        wlog.push_back(fb_addr);
        if (int'(fb_addr) < NPIX) begin
          hits[int'(fb_addr)]++;
          if (int'(fb_data) != (int'(fb_addr) % H) + (int'(fb_addr) / H)) data_bad++;
        end else data_bad++;
      end
      if (eng_start != 4'h0) begin
        start_cnt++;
        dlog.push_back({eng_y, eng_x});
      end
      if (frame_done) begin
        fdone_cnt++;
        if (busy) busy_bad++;
      end
    end
  end

  typedef struct {
    logic        rst_n;
    logic        req;
    logic [3:0]  ready;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  start;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [3:0]  ack;
    logic        we;
    logic [18:0] addr;
    logic [7:0]  data;
    logic        fd;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic start_frame();
    frame_req = 1'b1;
    @(posedge clk);
    #1 frame_req = 1'b0;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 400 && fdone_cnt == 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic wait_starts(input int n);
    for (int i = 0; i < 100 && start_cnt < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_frame(input string nm);
    int bad;
    bad = 0;
    for (int a = 0; a < NPIX; a++) if (hits[a] != 1) bad++;
    check({nm, ":frame_done_count"}, 64'(fdone_cnt), 64'd1);
    check({nm, ":write_count"}, 64'(wr_cnt), 64'(NPIX));
    check({nm, ":addr_once"}, 64'(bad), 64'd0);
    check({nm, ":data"}, 64'(data_bad), 64'd0);
    check({nm, ":busy_fall"}, 64'(busy_bad) + 64'(busy), 64'd0);
    check({nm, ":outstanding"}, 64'(dut.outstanding), 64'd0);
  endtask

  initial begin
    logic [63:0] act, exp;
    logic [9:0]  ax;
    logic [8:0]  ay;
    logic [18:0] aa;
    logic [7:0]  ad;
    int          snap, bad;

    rst_n = 1'b0; frame_req = 1'b0; t_ready = 4'h0; t_done = 4'h0; t_iter = 32'h44332211;
    model_on = 1'b0; stall = 1'b0; clr = 1'b0; en_mask = 4'h0;
    for (int k = 0; k < NE; k++) lat[k] = 3;

    //            rst  req  ready done  busy start x      y     ack   we    addr    data   fd
    tbl[0]  = '{1'b0,1'b1,4'hF,4'hF, 1'b0,4'h0,10'd0,9'd0,4'h0,1'b0,19'd0,8'h00,1'b0};
    tbl[1]  = '{1'b0,1'b1,4'hF,4'hF, 1'b0,4'h0,10'd0,9'd0,4'h0,1'b0,19'd0,8'h00,1'b0};
    tbl[2]  = '{1'b0,1'b1,4'hF,4'hF, 1'b0,4'h0,10'd0,9'd0,4'h0,1'b0,19'd0,8'h00,1'b0};
    tbl[3]  = '{1'b1,1'b1,4'hF,4'h0, 1'b1,4'h0,10'd0,9'd0,4'h0,1'b0,19'd0,8'h00,1'b0};
    tbl[4]  = '{1'b1,1'b0,4'hF,4'h0, 1'b1,4'h1,10'd0,9'd0,4'h0,1'b0,19'd0,8'h00,1'b0};
    tbl[5]  = '{1'b1,1'b0,4'hE,4'h0, 1'b1,4'h2,10'd1,9'd0,4'h0,1'b0,19'd0,8'h00,1'b0};
    tbl[6]  = '{1'b1,1'b0,4'hC,4'h0, 1'b1,4'h4,10'd2,9'd0,4'h0,1'b0,19'd0,8'h00,1'b0};
    tbl[7]  = '{1'b1,1'b0,4'h8,4'h0, 1'b1,4'h8,10'd3,9'd0,4'h0,1'b0,19'd0,8'h00,1'b0};
    tbl[8]  = '{1'b1,1'b0,4'h0,4'hF, 1'b1,4'h0,10'd0,9'd0,4'h1,1'b1,19'd0,8'h11,1'b0};
    tbl[9]  = '{1'b1,1'b0,4'h0,4'hE, 1'b1,4'h0,10'd0,9'd0,4'h2,1'b1,19'd1,8'h22,1'b0};
    tbl[10] = '{1'b1,1'b0,4'h0,4'hC, 1'b1,4'h0,10'd0,9'd0,4'h4,1'b1,19'd2,8'h33,1'b0};
    tbl[11] = '{1'b1,1'b0,4'h1,4'h8, 1'b1,4'h1,10'd0,9'd1,4'h8,1'b1,19'd3,8'h44,1'b0};
    tbl[12] = '{1'b1,1'b0,4'h0,4'h0, 1'b1,4'h0,10'd0,9'd0,4'h0,1'b0,19'd0,8'h00,1'b0};
    tbl[13] = '{1'b0,1'b0,4'h0,4'h0, 1'b0,4'h0,10'd0,9'd0,4'h0,1'b0,19'd0,8'h00,1'b0};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rst_n; frame_req = tbl[i].req; t_ready = tbl[i].ready; t_done = tbl[i].done;
      @(posedge clk);
      #1;
      ax = (tbl[i].start != 4'h0 || !tbl[i].rst_n) ? eng_x : 10'd0;
      ay = (tbl[i].start != 4'h0 || !tbl[i].rst_n) ? eng_y : 9'd0;
      aa = (tbl[i].we || !tbl[i].rst_n) ? fb_addr : 19'd0;
      ad = (tbl[i].we || !tbl[i].rst_n) ? fb_data : 8'd0;
      act = {7'd0, busy, eng_start, eng_ack, fb_we, frame_done, ax, ay, aa, ad};
      exp = {7'd0, tbl[i].busy, tbl[i].start, tbl[i].ack, tbl[i].we, tbl[i].fd,
             tbl[i].x, tbl[i].y, tbl[i].addr, tbl[i].data};
      check($sformatf("vec%0d", i), act, exp);
    end
    frame_req = 1'b0;

    // Small frame on two engines, fixed 3-cycle latency.
    model_on = 1'b1; en_mask = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    do_clr();
    start_frame();
    wait_frame();
    check_frame("small");

    // Engine 1 finishes before engine 0: address 1 lands first.
    lat[0] = 6; lat[1] = 1;
    do_clr();
    start_frame();
    wait_frame();
    check_frame("ooo");
    check("ooo:first_addr", (wlog.size() > 0) ? 64'(wlog[0]) : '1, 64'd1);

    // Back-pressure for 20 cycles with a stray FRAME_REQ in RUN.
    en_mask = 4'hF;
    for (int k = 0; k < NE; k++) lat[k] = 2;
    do_clr();
    start_frame();
    wait_starts(3);
    stall = 1'b1;
    snap = start_cnt;
    start_frame();
    repeat (19) @(negedge clk);
    #1;
    check("bp:no_start_while_stalled", 64'(start_cnt - snap), 64'd0);
    stall = 1'b0;
    wait_frame();
    check_frame("bp");
    check("bp:dispatch_count", 64'(dlog.size()), 64'(NPIX));
    bad = 0;
    for (int i = 0; i < dlog.size(); i++)
      if (dlog[i] != {9'(i / H), 10'(i % H)}) bad++;
    check("bp:dispatch_order", 64'(bad), 64'd0);

    // Reset mid-frame, then a clean restart from (0,0).
    do_clr();
    start_frame();
    wait_starts(2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid:outputs", {59'd0, busy, eng_start != 4'h0, eng_ack != 4'h0, fb_we, frame_done}, 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    do_clr();
    start_frame();
    wait_frame();
    check_frame("restart");
    check("restart:first_pixel", (dlog.size() > 0) ? 64'(dlog[0]) : '1, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
